oam_dma: RTL and testbench



---
 rtl/nes_bus_pkg.sv | 17 +
 rtl/oam_dma.sv | 107 ++++++++++
 tb/tb_oam_dma.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES console slice.
// Holds the fixed register addresses used by bus masters and the OAM DMA
// state encoding.
package nes_bus_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    DmaIdle,
    DmaHalt,
    DmaAlign,
    DmaRead,
    DmaWrite
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine behind the $4014 register.
// Snoops CPU-core writes to $4014, stalls the CPU via RDY, owns the shared bus
// and copies page $XX00-$XXFF into OAM as 256 read / $2004-write pairs.
//
// Ports:
//   i_cpu_clk, i_cpu_rstn   clock, asynchronous active-low reset
//   i_cpu_addr/wn/wdata     CPU-core bus request (pre-mux), wn=0 is a write
//   i_bus_rdata             shared-bus read data, valid with the address
//   o_cpu_rdy               CPU RDY, 0 while the DMA owns the bus
//   o_dma_busy              bus-mux select, 1 while the DMA owns the bus
//   o_dma_addr/wn/wdata     DMA bus request
//
// Build option: OAM_DMA_ALIGN_EN adds the parity-aligned ALIGN cycle
// (514-cycle transfers on odd-parity starts). Without it every transfer
// takes 513 cycles and no parity flop exists.
module oam_dma
  import nes_bus_pkg::*;
(
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_cpu_rdy,
  output logic        o_dma_busy,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata
);

  dma_state_e r_state, w_state_nxt;
  logic [7:0] r_page;
  logic [7:0] r_cnt;
  logic [7:0] r_data;
  logic       w_trigger;
  logic       w_need_align;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running CPU-cycle parity; the DMA never resets it.
  logic r_parity;
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) r_parity <= 1'b0;
    else             r_parity <= ~r_parity;
  end
  assign w_need_align = r_parity;
`else
  assign w_need_align = 1'b0;
`endif

  // Triggers are only seen in IDLE, so writes to $4014 while busy are dropped.
  assign w_trigger = (i_cpu_addr == ADDR_OAMDMA) && !i_cpu_wn && (r_state == DmaIdle);

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) r_state <= DmaIdle;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DmaIdle:  if (w_trigger) w_state_nxt = DmaHalt;
      DmaHalt:  w_state_nxt = w_need_align ? DmaAlign : DmaRead;
      DmaAlign: w_state_nxt = DmaRead;
      DmaRead:  w_state_nxt = DmaWrite;
      DmaWrite: w_state_nxt = (r_cnt == 8'hFF) ? DmaIdle : DmaRead;
      default:  w_state_nxt = DmaIdle;
    endcase
  end

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_page <= 8'h00;
      r_cnt  <= 8'h00;
      r_data <= 8'h00;
    end else begin
      if (w_trigger) begin
        r_page <= i_cpu_wdata;
        r_cnt  <= 8'h00;
      end
      if (r_state == DmaRead) r_data <= i_bus_rdata;
      // Last byte wraps the counter back to 0, ready for the next transfer.
      if (r_state == DmaWrite) r_cnt <= (r_cnt == 8'hFF) ? 8'h00 : r_cnt + 8'h01;
    end
  end

  // Moore output decode of the registered state.
  always_comb begin
    o_dma_busy  = 1'b1;
    o_dma_addr  = 16'h0000;
    o_dma_wn    = 1'b1;
    o_dma_wdata = 8'h00;
    unique case (r_state)
      DmaIdle:  o_dma_busy = 1'b0;
      DmaRead:  o_dma_addr = {r_page, r_cnt};
      DmaWrite: begin
        o_dma_addr  = ADDR_OAMDATA;
        o_dma_wn    = 1'b0;
        o_dma_wdata = r_data;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdy = ~o_dma_busy;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

  logic        clk;
  logic        rstn;
  logic [15:0] cpu_addr;
  logic        cpu_wn;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_busy;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected read addresses and expected $2004 write data.
  logic [15:0] rq[$];
  logic [7:0]  wq[$];
  int          lens[$];
  int          run = 0;
  int          gap = 0;
  int          last_gap = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  bit          saw_0800 = 0;
  logic        tb_par;

  oam_dma u_dut (
    .i_cpu_clk   (clk),
    .i_cpu_rstn  (rstn),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wn    (cpu_wn),
    .i_cpu_wdata (cpu_wdata),
    .i_bus_rdata (bus_rdata),
    .o_cpu_rdy   (cpu_rdy),
    .o_dma_busy  (dma_busy),
    .o_dma_addr  (dma_addr),
    .o_dma_wn    (dma_wn),
    .o_dma_wdata (dma_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_rdata = mem[dma_addr];

  // Reference model of the free-running parity flop.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      run = 0;
      gap = 0;
    end else begin
      n_cmp++;
      if (cpu_rdy !== ~dma_busy) begin
        n_bad++;
        $display("FAIL rdy_vs_busy: rdy=%b busy=%b (want rdy=~busy)", cpu_rdy, dma_busy);
      end
      if (dma_busy === 1'b1) begin
        if (run == 0) last_gap = gap;
        run++;
        if (dma_wn === 1'b0) begin
          n_wr++;
          n_cmp++;
          if (wq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: addr=%h data=%h (no write expected)",
                     dma_addr, dma_wdata);
          end else begin
            logic [7:0] exp_d;
            exp_d = wq.pop_front();
            if (dma_addr !== 16'h2004 || dma_wdata !== exp_d) begin
              n_bad++;
              $display("FAIL oam_write: addr=%h data=%h want addr=2004 data=%h",
                       dma_addr, dma_wdata, exp_d);
            end
          end
        end else if (dma_addr !== 16'h0000) begin
          n_rd++;
          if (dma_addr === 16'h0800) saw_0800 = 1;
          n_cmp++;
          if (rq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_read: addr=%h (no read expected)", dma_addr);
          end else begin
            logic [15:0] exp_a;
            exp_a = rq.pop_front();
            if (dma_addr !== exp_a) begin
              n_bad++;
              $display("FAIL read_addr: addr=%h want %h", dma_addr, exp_a);
            end
          end
        end
      end else begin
        if (run != 0) begin
          lens.push_back(run);
          run = 0;
          gap = 0;
        end
        gap++;
      end
    end
  end

  // Called at posedge+#1. want_odd: 0/1 picks the HALT parity, -1 triggers now.
  task automatic trigger(input logic [7:0] page, input int want_odd, output int exp_len);
    int guard;
    bit halt_odd;
    guard = 0;
    while (want_odd >= 0 && int'(!tb_par) != want_odd && guard < 4) begin
      @(posedge clk); #1;
      guard++;
    end
    halt_odd = !tb_par;
    for (int i = 0; i < 256; i++) begin
      rq.push_back({page, i[7:0]});
      wq.push_back(mem[{page, i[7:0]}]);
    end
    exp_len = 513;
`ifdef OAM_DMA_ALIGN_EN
    if (halt_odd) exp_len = 514;
`endif
    cpu_addr  = 16'h4014;
    cpu_wn    = 1'b0;
    cpu_wdata = page;
    @(posedge clk); #1;
    cpu_addr  = 16'h0000;
    cpu_wn    = 1'b1;
    cpu_wdata = 8'h00;
  endtask

  task automatic wait_runs(input int n, input string name);
    int cyc;
    cyc = 0;
    while (lens.size() < n && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (lens.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: runs=%0d want %0d", name, lens.size(), n);
    end
  endtask

  task automatic check_done(input string name, input int exp_len);
    int got;
    got = (lens.size() > 0) ? lens.pop_front() : -1;
    n_cmp++;
    if (got !== exp_len) begin
      n_bad++;
      $display("FAIL %s_len: busy=%0d want %0d", name, got, exp_len);
    end
    n_cmp++;
    if (rq.size() != 0 || wq.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: reads_left=%0d writes_left=%0d want 0/0",
               name, rq.size(), wq.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || dma_wn !== 1'b1 ||
        dma_addr !== 16'h0000 || dma_wdata !== 8'h00) begin
      n_bad++;
      $display("FAIL %s: rdy=%b busy=%b wn=%b addr=%h wdata=%h want 1 0 1 0000 00",
               name, cpu_rdy, dma_busy, dma_wn, dma_addr, dma_wdata);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_in");
    rstn = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_out");
  endtask

  task automatic test_basic();
    int el;
    trigger(8'h02, 0, el);
    wait_runs(1, "basic");
    check_done("basic", el);
    n_cmp++;
    if (el != 513) begin
      n_bad++;
      $display("FAIL basic_even: model_len=%0d want 513", el);
    end
  endtask

  task automatic test_odd_parity();
    int el;
    int want;
    want = 513;
`ifdef OAM_DMA_ALIGN_EN
    want = 514;
`endif
    trigger(8'h02, 1, el);
    wait_runs(1, "odd");
    check_done("odd", want);
  endtask

  task automatic test_sweep();
    int el;
    int rd0;
    rd0 = n_rd;
    saw_0800 = 0;
    trigger(8'h07, 0, el);
    wait_runs(1, "sweep");
    check_done("sweep", el);
    n_cmp++;
    if (n_rd - rd0 != 256 || saw_0800) begin
      n_bad++;
      $display("FAIL sweep_reads: reads=%0d saw0800=%0d want 256/0", n_rd - rd0, saw_0800);
    end
  endtask

  task automatic test_reset_mid();
    int el;
    int wr0;
    int cyc;
    wr0 = n_wr;
    cyc = 0;
    trigger(8'h05, -1, el);
    while (n_wr - wr0 < 100 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (n_wr - wr0 != 100) begin
      n_bad++;
      $display("FAIL midreset_pos: writes=%0d want 100", n_wr - wr0);
    end
    rstn = 1'b0;
    #1;
    check_idle_outputs("midreset_out");
    rq.delete();
    wq.delete();
    lens.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    trigger(8'h09, -1, el);
    wait_runs(1, "restart");
    check_done("restart", el);
  endtask

  task automatic test_retrigger();
    int el;
    trigger(8'h03, 0, el);
    repeat (40) @(posedge clk);
    #1;
    cpu_addr  = 16'h4014;
    cpu_wn    = 1'b0;
    cpu_wdata = 8'h0C;
    @(posedge clk); #1;
    cpu_addr  = 16'h0000;
    cpu_wn    = 1'b1;
    cpu_wdata = 8'h00;
    wait_runs(1, "retrig");
    check_done("retrig", el);
  endtask

  task automatic test_back_to_back();
    int el1;
    int el2;
    int cyc;
    int l1;
    int l2;
    trigger(8'h04, -1, el1);
    cyc = 0;
    while (dma_busy !== 1'b0 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    trigger(8'h06, -1, el2);
    wait_runs(2, "b2b");
    l1 = (lens.size() > 0) ? lens[0] : 0;
    l2 = (lens.size() > 1) ? lens[1] : 0;
    n_cmp++;
    if (l1 + l2 < 1026 || last_gap != 1) begin
      n_bad++;
      $display("FAIL b2b_total: busy=%0d gap=%0d want >=1026 gap=1", l1 + l2, last_gap);
    end
    n_cmp++;
    if (l1 != el1) begin
      n_bad++;
      $display("FAIL b2b_len1: busy=%0d want %0d", l1, el1);
    end
    if (lens.size() > 0) void'(lens.pop_front());
    check_done("b2b2", el2);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = i[7:0] ^ 8'h5A;
    rstn      = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wn    = 1'b1;
    cpu_wdata = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_odd_parity();
    test_sweep();
    test_reset_mid();
    test_retrigger();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
